// File: rtl/atm_session_ctrl.sv
// ATM session controller: card -> PIN -> menu -> balance check -> cash handshake -> card return.
// Optional inactivity timeout is built only when ATM_TIMEOUT_EN is defined.
module atm_session_ctrl #(
    parameter int BAL_W          = 8,
    parameter int MAX_PIN_TRIES  = 3,
    parameter int INIT_BALANCE   = 20,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_card_in,
    input  logic             i_pin_valid,
    input  logic             i_pin_ok,
    input  logic             i_choice_valid,
    input  logic             i_choice,
    input  logic [1:0]       i_amount,
    input  logic             i_cancel,
    output logic             o_disp_req,
    output logic             o_disp_op,
    output logic [1:0]       o_disp_amount,
    input  logic             i_disp_ack,
    output logic             o_card_eject,
    output logic             o_card_retain,
    output logic             o_txn_done,
    output logic             o_txn_err,
    output logic [1:0]       o_err_code,
    output logic [BAL_W-1:0] o_balance,
    output logic [2:0]       o_state
);

    // Handshake: o_disp_req rises on entry to XFER and holds, with o_disp_op and
    // o_disp_amount stable, until i_disp_ack is sampled high at a rising edge; after
    // that edge o_disp_req is low and the balance already reflects the transfer.

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_PIN    = 3'b001,
        S_MENU   = 3'b010,
        S_CHECK  = 3'b011,
        S_XFER   = 3'b100,
        S_EJECT  = 3'b101,
        S_RETAIN = 3'b110
    } state_t;

    localparam logic [1:0] ERR_PIN     = 2'b00;
    localparam logic [1:0] ERR_BALANCE = 2'b01;
    localparam logic [1:0] ERR_AMOUNT  = 2'b10;

    if (MAX_PIN_TRIES < 1 || MAX_PIN_TRIES > 7 || TIMEOUT_CYCLES < 2 || BAL_W < 3) begin : g_bad_params
        $error("atm_session_ctrl: illegal parameter set");
    end

    state_t           r_state;
    state_t           w_next;
    logic [2:0]       r_tries;
    logic [2:0]       w_tries;
    logic [2:0]       w_tries_inc;
    logic             r_choice;
    logic [1:0]       r_amount;
    logic             w_latch;
    logic [BAL_W-1:0] r_balance;
    logic [BAL_W-1:0] w_balance;
    logic [1:0]       r_err_code;
    logic [1:0]       w_err_code;
    logic             w_txn_err;
    logic             w_txn_done;
    logic             w_timeout;

    logic             r_disp_req;
    logic             r_disp_op;
    logic [1:0]       r_disp_amount;
    logic             r_card_eject;
    logic             r_card_retain;
    logic             r_txn_done;
    logic             r_txn_err;

    logic [2:0]       w_units3;
    logic [BAL_W-1:0] w_units;
    logic [BAL_W:0]   w_sum;
    logic             w_overdraw;
    logic             w_overflow;

    // Amount code to 50000-unit multiples: 01->1, 10->2, 11->4.
    always_comb begin
        w_units3 = 3'd0;
        case (r_amount)
            2'b01:   w_units3 = 3'd1;
            2'b10:   w_units3 = 3'd2;
            2'b11:   w_units3 = 3'd4;
            default: w_units3 = 3'd0;
        endcase
    end

    assign w_units     = BAL_W'(w_units3);
    assign w_sum       = {1'b0, r_balance} + {1'b0, w_units};
    assign w_overdraw  = (w_units > r_balance);
    assign w_overflow  = w_sum[BAL_W];
    assign w_tries_inc = r_tries + 3'd1;

`ifdef ATM_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    logic [TO_W-1:0] r_to_cnt;
    logic            w_to_clear;

    assign w_to_clear = (w_next != r_state) || i_pin_valid || i_choice_valid;
    assign w_timeout  = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to_cnt <= '0;
        end else if (w_to_clear) begin
            r_to_cnt <= '0;
        end else if (!w_timeout) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next     = r_state;
        w_tries    = r_tries;
        w_latch    = 1'b0;
        w_balance  = r_balance;
        w_err_code = r_err_code;
        w_txn_err  = 1'b0;
        w_txn_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_card_in) begin
                    w_next  = S_PIN;
                    w_tries = 3'd0;
                end
            end
            S_PIN: begin
                if (!i_card_in) begin
                    w_next = S_IDLE;
                end else if (i_pin_valid) begin
                    if (i_pin_ok) begin
                        w_next = S_MENU;
                    end else begin
                        w_tries = w_tries_inc;
                        if (w_tries_inc >= 3'(MAX_PIN_TRIES)) begin
                            w_next     = S_RETAIN;
                            w_txn_err  = 1'b1;
                            w_err_code = ERR_PIN;
                        end
                    end
                end else if (i_cancel) begin
                    w_next = S_EJECT;
`ifdef ATM_TIMEOUT_EN
                end else if (w_timeout) begin
                    w_next     = S_EJECT;
                    w_txn_err  = 1'b1;
                    w_err_code = ERR_TIMEOUT;
`endif
                end
            end
            S_MENU: begin
                if (!i_card_in) begin
                    w_next = S_IDLE;
                end else if (i_choice_valid) begin
                    w_latch = 1'b1;
                    w_next  = S_CHECK;
                end else if (i_cancel) begin
                    w_next = S_EJECT;
`ifdef ATM_TIMEOUT_EN
                end else if (w_timeout) begin
                    w_next     = S_EJECT;
                    w_txn_err  = 1'b1;
                    w_err_code = ERR_TIMEOUT;
`endif
                end
            end
            S_CHECK: begin
                if (r_amount == 2'b00) begin
                    w_next     = S_EJECT;
                    w_txn_err  = 1'b1;
                    w_err_code = ERR_AMOUNT;
                end else if ((r_choice && w_overdraw) || (!r_choice && w_overflow)) begin
                    w_next     = S_EJECT;
                    w_txn_err  = 1'b1;
                    w_err_code = ERR_BALANCE;
                end else begin
                    w_next = S_XFER;
                end
            end
            S_XFER: begin
                // Ack wins over a timeout that expires on the same cycle.
                if (i_disp_ack) begin
                    w_balance  = r_choice ? (r_balance - w_units) : w_sum[BAL_W-1:0];
                    w_txn_done = 1'b1;
                    w_next     = S_EJECT;
`ifdef ATM_TIMEOUT_EN
                end else if (w_timeout) begin
                    w_next     = S_EJECT;
                    w_txn_err  = 1'b1;
                    w_err_code = ERR_TIMEOUT;
`endif
                end
            end
            S_EJECT: begin
                if (!i_card_in) begin
                    w_next = S_IDLE;
                end
            end
            S_RETAIN: begin
                if (!i_card_in) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_tries    <= 3'd0;
            r_choice   <= 1'b0;
            r_amount   <= 2'b00;
            r_balance  <= BAL_W'(INIT_BALANCE);
            r_err_code <= ERR_PIN;
        end else begin
            r_state    <= w_next;
            r_tries    <= w_tries;
            r_balance  <= w_balance;
            r_err_code <= w_err_code;
            if (w_latch) begin
                r_choice <= i_choice;
                r_amount <= i_amount;
            end
        end
    end

    // Outputs are registered from the next state so they line up with o_state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_disp_req    <= 1'b0;
            r_disp_op     <= 1'b0;
            r_disp_amount <= 2'b00;
            r_card_eject  <= 1'b0;
            r_card_retain <= 1'b0;
            r_txn_done    <= 1'b0;
            r_txn_err     <= 1'b0;
        end else begin
            r_disp_req    <= (w_next == S_XFER);
            r_disp_op     <= (w_next == S_XFER) ? r_choice : 1'b0;
            r_disp_amount <= (w_next == S_XFER) ? r_amount : 2'b00;
            r_card_eject  <= (w_next == S_EJECT);
            r_card_retain <= (w_next == S_RETAIN);
            r_txn_done    <= w_txn_done;
            r_txn_err     <= w_txn_err;
        end
    end

    assign o_disp_req    = r_disp_req;
    assign o_disp_op     = r_disp_op;
    assign o_disp_amount = r_disp_amount;
    assign o_card_eject  = r_card_eject;
    assign o_card_retain = r_card_retain;
    assign o_txn_done    = r_txn_done;
    assign o_txn_err     = r_txn_err;
    assign o_err_code    = r_err_code;
    assign o_balance     = r_balance;
    assign o_state       = r_state;

endmodule

// File: doc/atm_session_ctrl.md
# atm_session_ctrl

Session controller that sequences one ATM customer transaction from card insertion to card return: it checks the PIN with a bounded retry count and captures the deposit/withdraw selection and amount. It validates the amount against an on-chip balance register and drives a req/ack handshake to the cash-handling unit. It sits between the front-panel inputs (card slot, keypad, menu buttons) and the dispenser/acceptor mechanism, and is the only writer of the account balance.

## Interface
- BAL_W, 8: balance width, in units of 50000.
- MAX_PIN_TRIES, 3: wrong PINs allowed before the card is retained (1..7).
- INIT_BALANCE, 20: balance value after reset, in 50000 units.
- TIMEOUT_CYCLES, 1024: inactivity limit in cycles (used only with ATM_TIMEOUT_EN).
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- card_in  in  1  level; card present in slot.
- pin_valid  in  1  one-cycle strobe; PIN entry complete.
- pin_ok  in  1  PIN correct; qualified by pin_valid.
- choice_valid  in  1  one-cycle strobe; choice and amount are valid.
- choice  in  1  0 = deposit, 1 = withdraw.
- amount  in  2  01 = 50000, 10 = 100000, 11 = 200000, 00 = invalid.
- cancel  in  1  level; customer abort.
- disp_req  out  1  request to cash unit.
- disp_op  out  1  0 = accept deposit, 1 = dispense; stable while disp_req is high.
- disp_amount  out  2  amount code; stable while disp_req is high.
- disp_ack  in  1  cash unit finished; sampled only while disp_req is high.
- card_eject  out  1  level; return card.
- card_retain  out  1  level; swallow card.
- txn_done  out  1  one-cycle pulse; transaction committed.
- txn_err  out  1  one-cycle pulse; transaction aborted with error.
- err_code  out  2  last error: 00 PIN lockout, 01 balance, 10 invalid amount, 11 timeout.
- balance  out  BAL_W  current balance.
- state_o  out  3  current state encoding.

## Operation
- States and encodings: IDLE 000, PIN 001, MENU 010, CHECK 011, XFER 100, EJECT 101, RETAIN 110. Unused encodings go to IDLE.
- IDLE: when card_in = 1, go to PIN and clear the try counter.
- PIN:
  - pin_valid with pin_ok = 1: go to MENU.
  - pin_valid with pin_ok = 0: increment the try counter. When the counter reaches MAX_PIN_TRIES, go to RETAIN and pulse txn_err with err_code 00.
- MENU: on choice_valid, latch choice and amount, then go to CHECK.
- CHECK (exactly one cycle). Amount codes map to units 01→1, 10→2, 11→4.
  - amount = 00: txn_err, err_code 10, go to EJECT.
  - Withdraw with units > balance: txn_err, err_code 01, go to EJECT.
  - Deposit with balance + units > 2^BAL_W − 1: txn_err, err_code 01, go to EJECT.
  - Otherwise go to XFER.
- XFER: hold disp_req, disp_op and disp_amount. On the cycle disp_ack is sampled high, update balance (+ or − units), pulse txn_done, and go to EJECT.
- EJECT: card_eject is high until card_in = 0, then go to IDLE.
- RETAIN: card_retain is high until card_in = 0, then go to IDLE.
- cancel in PIN or MENU: go to EJECT, with no txn_err. cancel is ignored in CHECK and XFER.
- card_in = 0 in PIN or MENU: go directly to IDLE.
- PIN has priority over cancel if pin_valid and cancel occur in the same cycle. MENU: choice_valid has priority over cancel.
- err_code holds its value until the next error.
- Balance arithmetic is unsigned at BAL_W bits. The error checks in CHECK guarantee it never wraps.

## Timing
- Reset state: IDLE.
- Reset values of outputs: disp_req 0, disp_op 0, disp_amount 00, card_eject 0, card_retain 0, txn_done 0, txn_err 0, err_code 00, balance INIT_BALANCE, state_o 000.
- All outputs are registered.
- choice_valid in MENU to disp_req high: 2 cycles (MENU→CHECK, CHECK→XFER).
- disp_ack sampled high at edge N: disp_req is low, balance is updated and txn_done is high after edge N. State is EJECT after edge N.
- Reset asserted mid-XFER: disp_req drops immediately (asynchronous) and balance returns to INIT_BALANCE.

## Configuration
- ATM_TIMEOUT_EN defined:
  - An inactivity counter clears on every state change and on every pin_valid or choice_valid strobe.
  - In PIN, MENU or XFER, reaching TIMEOUT_CYCLES − 1 gives txn_err with err_code 11, drops disp_req, leaves balance unchanged, and goes to EJECT.
- ATM_TIMEOUT_EN undefined: no counter is built, err_code 11 is never produced, and PIN/MENU/XFER wait indefinitely.

## Test plan
- Card in, correct PIN, withdraw 10 from INIT_BALANCE 20, ack after 5 cycles → disp_req high 2 cycles after choice_valid, disp_op 1, disp_amount 10, balance 18, one txn_done pulse, card_eject until card removed.
- Three wrong PINs → txn_err with err_code 00, card_retain high, balance unchanged, IDLE after card_in drops.
- Withdraw 11 with balance 3 → txn_err, err_code 01, no disp_req, EJECT.
- Deposit 11 with balance 253 (BAL_W 8) → err_code 01. Deposit 01 with balance 254 → balance 255.
- amount 00 → err_code 10. cancel in MENU → EJECT with no txn_err. cancel during XFER is ignored.
- ATM_TIMEOUT_EN with TIMEOUT_CYCLES 16, no disp_ack → txn_err with err_code 11 on the 16th XFER cycle, disp_req drops, balance unchanged. Reset mid-XFER → all outputs at reset values.
